tt_um_cats_are_fluffy: RTL and testbench
========================================

Name: tt_um_cats_are_fluffy

Overview:
- TinyTapeout user tile implementing an 8-deep, 8-bit RPN stack calculator.
- Operand is taken from ui_in; opcode and strobe come from uio_in.
- Top-of-stack (TOS) drives uo_out; status flags drive the upper uio pins.
- Sits directly under the TT harness, with no submodules required beyond the stack register file.

Parameters:
- DEPTH, 8, number of stack entries (count register width is clog2(DEPTH)+1).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- ena  input  1  tile enable; while low, no command executes and all state holds.
- ui_in  input  8  operand for PUSH.
- uo_out  output  8  current TOS; 0 when stack is empty.
- uio_in  input  8  [3:0] opcode; [4] command strobe; [7:5] ignored.
- uio_out  output  8  [7] error (sticky); [6] carry; [5] zero; [4:0] constant 0.
- uio_oe  output  8  constant 8'b1110_0000.

Behaviour:
- Reset (rst_n=0, async):
  - All stack entries cleared to 0; count=0; carry=0; error=0; strobe history=0.
  - uo_out=0 and uio_out=8'h20 (zero flag set).
- Strobe edge detect:
  - strb_q is a register that samples uio_in[4] every clock while ena=1.
  - A command executes on the clock edge where ena=1, uio_in[4]=1 and strb_q=0.
  - Exactly one command executes per strobe rising edge, however long the strobe is held.
- Latency: the result is visible on uo_out/uio_out immediately after the executing clock edge. All outputs are registered state or pure decode of registered state.
- Stack model:
  - NOS is the entry below TOS.
  - "Needs n" means the op requires count>=n. If the requirement is not met: error<=1 and the stack, count and carry are unchanged.
- Opcodes:
  - 0 NOP: nothing.
  - 1 PUSH: needs count<DEPTH, else error. TOS<=ui_in; count+1.
  - 2 POP: needs 1. count-1.
  - 3 ADD: needs 2. r=NOS+TOS (9-bit); NOS<=r[7:0]; carry<=r[8]; count-1.
  - 4 SUB: needs 2. NOS<=NOS-TOS mod 256; carry<=1 if NOS<TOS (borrow); count-1.
  - 5 AND, 6 OR, 7 XOR: needs 2. NOS<=NOS op TOS; count-1; carry unchanged.
  - 8 NOT: needs 1. TOS<=~TOS.
  - 9 SHL: needs 1. carry<=TOS[7]; TOS<=TOS<<1.
  - A SHR: needs 1. carry<=TOS[0]; TOS<=TOS>>1 (logical).
  - B DUP: needs 1 and count<DEPTH. Pushes a copy of TOS.
  - C SWAP: needs 2. Exchanges TOS and NOS.
  - D OVER: needs 2 and count<DEPTH. Pushes a copy of NOS.
  - E CLR: count<=0; all entries<=0; carry<=0; error<=0.
  - F: reserved, behaves as NOP.
- Flags:
  - Carry changes only on ADD, SUB, SHL, SHR and CLR.
  - Error is sticky; only CLR or reset clears it.
  - Zero = (uo_out==0), including the empty-stack case.
- Entries above count are don't-care internally but must never appear on uo_out.
- ena low mid-strobe: strb_q holds its value, so a strobe that is still high when ena returns does not re-trigger.
- Reset asserted mid-operation: immediate return to reset state; the pending strobe is lost.

Test Plan:
- Reset, then PUSH 0x05, PUSH 0x03 -> uo_out=0x03. Then ADD -> uo_out=0x08, uio_out=0x00.
- PUSH 0xF0, PUSH 0x20, ADD -> uo_out=0x10, carry set (uio_out=0x40). PUSH 0x10, SUB -> uo_out=0x00, uio_out=0x20 (zero set, carry=0 since no borrow).
- From empty: POP -> error set, uio_out=0xA0, uo_out=0. Then PUSH 0x01 -> uo_out=0x01, error remains set (uio_out=0x80). Then CLR -> uio_out=0x20.
- PUSH 1..8 (eight pushes) then PUSH 0x09 -> uo_out stays 0x08 and error sets. Then DUP -> uo_out stays 0x08, error stays set.
- Hold strobe high for 10 cycles with opcode PUSH 0x7E -> exactly one push (a following POP gives an empty stack, uo_out=0). With ena=0, strobe pulses -> no state change.
- PUSH 0x81, SHR -> uo_out=0x40, carry=1. SHL -> uo_out=0x80, carry=0. PUSH 0x11, SWAP -> uo_out=0x80. OVER -> uo_out=0x11.

Source files
------------

// File: rtl/tt_um_cats_are_fluffy.sv
// TinyTapeout tile: 8-bit RPN stack calculator. One command executes per rising
// edge of uio_in[4]; TOS is driven on uo_out and the flags on uio_out[7:5].
module tt_um_cats_are_fluffy #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0, OP_PUSH = 4'h1, OP_POP  = 4'h2, OP_ADD  = 4'h3,
    OP_SUB  = 4'h4, OP_AND  = 4'h5, OP_OR   = 4'h6, OP_XOR  = 4'h7,
    OP_NOT  = 4'h8, OP_SHL  = 4'h9, OP_SHR  = 4'hA, OP_DUP  = 4'hB,
    OP_SWAP = 4'hC, OP_OVER = 4'hD, OP_CLR  = 4'hE, OP_RSVD = 4'hF
  } op_t;

  logic [7:0]    stk [DEPTH];
  logic [CW-1:0] count;
  logic          carry;
  logic          error;
  logic          strb_q;

  logic          fire;
  op_t           op;
  logic [AW-1:0] tos_i, nos_i, push_i;
  logic [7:0]    tos, nos;
  logic          has1, has2, room;
  logic [8:0]    sum9;
  logic          unused_ok;

  assign op     = op_t'(uio_in[3:0]);
  assign fire   = ena & uio_in[4] & ~strb_q;

  // Indices wrap harmlessly: they are only used when the count check passes.
  assign tos_i  = AW'(count - CW'(1));
  assign nos_i  = AW'(count - CW'(2));
  assign push_i = AW'(count);
  assign tos    = stk[tos_i];
  assign nos    = stk[nos_i];
  assign has1   = (count >= CW'(1));
  assign has2   = (count >= CW'(2));
  assign room   = (count < CW'(DEPTH));
  assign sum9   = {1'b0, nos} + {1'b0, tos};

  assign uo_out    = has1 ? tos : 8'h00;
  assign uio_out   = {error, carry, (uo_out == 8'h00), 5'b0_0000};
  assign uio_oe    = 8'b1110_0000;
  assign unused_ok = &{1'b0, uio_in[7:5]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stk[i] <= 8'h00;
      count  <= '0;
      carry  <= 1'b0;
      error  <= 1'b0;
      strb_q <= 1'b0;
    end else if (ena) begin
      strb_q <= uio_in[4];
      if (fire) begin
        unique case (op)
          OP_PUSH: if (room) begin
            stk[push_i] <= ui_in;
            count       <= count + CW'(1);
          end else error <= 1'b1;
          OP_POP: if (has1) count <= count - CW'(1);
                  else error <= 1'b1;
          OP_ADD: if (has2) begin
            stk[nos_i] <= sum9[7:0];
            carry      <= sum9[8];
            count      <= count - CW'(1);
          end else error <= 1'b1;
          OP_SUB: if (has2) begin
            stk[nos_i] <= nos - tos;
            carry      <= (nos < tos);
            count      <= count - CW'(1);
          end else error <= 1'b1;
          OP_AND, OP_OR, OP_XOR: if (has2) begin
            stk[nos_i] <= (op == OP_AND) ? (nos & tos) :
                          (op == OP_OR)  ? (nos | tos) : (nos ^ tos);
            count      <= count - CW'(1);
          end else error <= 1'b1;
          OP_NOT: if (has1) stk[tos_i] <= ~tos;
                  else error <= 1'b1;
          OP_SHL: if (has1) begin
            carry      <= tos[7];
            stk[tos_i] <= {tos[6:0], 1'b0};
          end else error <= 1'b1;
          OP_SHR: if (has1) begin
            carry      <= tos[0];
            stk[tos_i] <= {1'b0, tos[7:1]};
          end else error <= 1'b1;
          OP_DUP: if (has1 && room) begin
            stk[push_i] <= tos;
            count       <= count + CW'(1);
          end else error <= 1'b1;
          OP_SWAP: if (has2) begin
            stk[tos_i] <= nos;
            stk[nos_i] <= tos;
          end else error <= 1'b1;
          OP_OVER: if (has2 && room) begin
            stk[push_i] <= nos;
            count       <= count + CW'(1);
          end else error <= 1'b1;
          OP_CLR: begin
            for (int i = 0; i < DEPTH; i++) stk[i] <= 8'h00;
            count <= '0;
            carry <= 1'b0;
            error <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tt_um_cats_are_fluffy.sv
// Directed bench for the RPN stack tile: hand-computed TOS and flag values.
module tb_tt_um_cats_are_fluffy;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_run  = 0;
  int n_fail = 0;

  localparam logic [3:0] NOP = 4'h0, PUSH = 4'h1, POP = 4'h2, ADD = 4'h3,
                         SUB = 4'h4, AND = 4'h5, OR = 4'h6, XOR = 4'h7,
                         NOT = 4'h8, SHL = 4'h9, SHR = 4'hA, DUP = 4'hB,
                         SWAP = 4'hC, OVER = 4'hD, CLR = 4'hE;

  tt_um_cats_are_fluffy #(.DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo_out),
    .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  // Strobe high for one edge, then low for one edge so the detector re-arms.
  task automatic cmd(input logic [3:0] op, input logic [7:0] val);
    @(negedge clk);
    ui_in  = val;
    uio_in = {3'b000, 1'b1, op};
    @(negedge clk);
    uio_in[4] = 1'b0;
    @(negedge clk);
  endtask

  task automatic expect_out(input string tag, input logic [7:0] tos, input logic [7:0] flags);
    check({tag, ".tos"}, uo_out, tos);
    check({tag, ".flg"}, uio_out, flags);
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; ui_in = 8'h00; uio_in = 8'h00;
    repeat (2) @(negedge clk);
    check("rst.tos", uo_out, 8'h00);
    check("rst.flg", uio_out, 8'h20);
    check("rst.oe", uio_oe, 8'hE0);
    rst_n = 1'b1;
    @(negedge clk);

    cmd(PUSH, 8'h05); cmd(PUSH, 8'h03);
    expect_out("push2", 8'h03, 8'h00);
    cmd(ADD, 8'h00);
    expect_out("add", 8'h08, 8'h00);

    cmd(PUSH, 8'hF0); cmd(PUSH, 8'h20); cmd(ADD, 8'h00);
    expect_out("add_cy", 8'h10, 8'h40);
    cmd(PUSH, 8'h10); cmd(SUB, 8'h00);
    expect_out("sub_z", 8'h00, 8'h20);
    cmd(POP, 8'h00);
    expect_out("pop", 8'h08, 8'h00);
    cmd(PUSH, 8'h09); cmd(SUB, 8'h00);
    expect_out("sub_bor", 8'hFF, 8'h40);

    cmd(CLR, 8'h00);
    expect_out("clr0", 8'h00, 8'h20);
    cmd(POP, 8'h00);
    expect_out("pop_emp", 8'h00, 8'hA0);
    cmd(PUSH, 8'h01);
    expect_out("err_stk", 8'h01, 8'h80);
    cmd(CLR, 8'h00);
    expect_out("clr1", 8'h00, 8'h20);

    for (int i = 1; i <= 8; i++) cmd(PUSH, 8'(i));
    expect_out("full", 8'h08, 8'h00);
    cmd(PUSH, 8'h09);
    expect_out("ovf", 8'h08, 8'h80);
    cmd(DUP, 8'h00);
    expect_out("dup_ovf", 8'h08, 8'h80);
    cmd(POP, 8'h00);
    expect_out("pop_full", 8'h07, 8'h80);
    cmd(CLR, 8'h00);

    // Long strobe: exactly one push.
    @(negedge clk);
    ui_in = 8'h7E; uio_in = {3'b000, 1'b1, PUSH};
    repeat (10) @(negedge clk);
    uio_in[4] = 1'b0;
    @(negedge clk);
    expect_out("hold", 8'h7E, 8'h00);
    cmd(POP, 8'h00);
    expect_out("hold_pop", 8'h00, 8'h20);

    // Strobe pulse while disabled does nothing.
    ena = 1'b0;
    cmd(PUSH, 8'h55);
    ena = 1'b1;
    @(negedge clk);
    expect_out("ena0", 8'h00, 8'h20);

    // Disable mid-strobe and re-enable with the strobe still high: one push only.
    @(negedge clk);
    ui_in = 8'h33; uio_in = {3'b000, 1'b1, PUSH};
    @(negedge clk);
    ena = 1'b0;
    repeat (3) @(negedge clk);
    ena = 1'b1;
    repeat (3) @(negedge clk);
    uio_in[4] = 1'b0;
    @(negedge clk);
    cmd(POP, 8'h00);
    expect_out("ena_mid", 8'h00, 8'h20);

    cmd(PUSH, 8'h81); cmd(SHR, 8'h00);
    expect_out("shr", 8'h40, 8'h40);
    cmd(SHL, 8'h00);
    expect_out("shl", 8'h80, 8'h00);
    cmd(PUSH, 8'h11); cmd(SWAP, 8'h00);
    expect_out("swap", 8'h80, 8'h00);
    cmd(OVER, 8'h00);
    expect_out("over", 8'h11, 8'h00);
    cmd(XOR, 8'h00);
    expect_out("xor", 8'h91, 8'h00);
    cmd(AND, 8'h00);
    expect_out("and", 8'h11, 8'h00);
    cmd(NOT, 8'h00);
    expect_out("not", 8'hEE, 8'h00);
    cmd(PUSH, 8'h0F); cmd(OR, 8'h00);
    expect_out("or", 8'hEF, 8'h00);
    cmd(NOP, 8'h00); cmd(4'hF, 8'h00);
    expect_out("nop", 8'hEF, 8'h00);
    cmd(PUSH, 8'hFF); cmd(ADD, 8'h00);
    expect_out("add_cy2", 8'hEE, 8'h40);

    // Asynchronous reset away from a clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    expect_out("arst", 8'h00, 8'h20);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    expect_out("arst_hold", 8'h00, 8'h20);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
